cache_ctrl: RTL and testbench
=============================

CACHE_CTRL -- requirements
Module: cache_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte address width.
REQ-002 SHALL have parameter INDEX_W, default 4, log2 of line count (16 lines, direct-mapped).
REQ-003 SHALL have parameter OFFSET_W, default 2, log2 of bytes per line (4 bytes).
REQ-004 SHALL have ports:
- clk_i  in  1  clock; all state changes on rising edge.
- rst_ni  in  1  reset; asynchronous, active-low.
- req_i  in  1  read request valid.
- addr_i  in  ADDR_W  read byte address; tag = [ADDR_W-1:INDEX_W+OFFSET_W], index = [INDEX_W+OFFSET_W-1:OFFSET_W], offset = [OFFSET_W-1:0].
- ready_o  out  1  controller can accept a request.
- rvalid_o  out  1  rdata_o valid; one-cycle pulse.
- rdata_o  out  8  read byte.
- flush_i  in  1  invalidate all lines.
- mem_req_o  out  1  backing-memory byte read request.
- mem_addr_o  out  ADDR_W  backing-memory byte address.
- mem_ack_i  in  1  backing memory returns mem_data_i this cycle.
- mem_data_i  in  8  backing-memory read byte.
- hit_cnt_o  out  16  hit counter.
- miss_cnt_o  out  16  miss counter.

Function
REQ-005 SHALL implement FSM states IDLE, LOOKUP, REFILL, RESPOND, FLUSH; ready_o = 1 only in IDLE.
REQ-006 In IDLE, flush_i high SHALL enter FLUSH; otherwise req_i high SHALL latch addr_i and enter LOOKUP. flush_i wins when both are high; the request is not accepted.
REQ-007 LOOKUP SHALL compare the latched tag with tag[index] and valid[index].
- On hit: increment hit_cnt_o, load rdata_o from data[index][offset], enter RESPOND.
- On miss: increment miss_cnt_o, clear valid[index], clear the beat counter, enter REFILL.
REQ-008 RESPOND SHALL hold rvalid_o = 1 for exactly one cycle, then return to IDLE. Hit latency is 2 cycles from the accepting edge to the rvalid_o cycle.
REQ-009 In REFILL, mem_req_o SHALL be 1 and mem_addr_o SHALL equal {latched tag, index, beat}, beat counting from 0 to 2^OFFSET_W-1.
REQ-010 mem_req_o and mem_addr_o SHALL hold stable until mem_ack_i = 1. On an ack edge, mem_data_i is written to data[index][beat] and beat increments.
REQ-011 On the ack of the last beat, the controller SHALL:
- set valid[index] and write tag[index];
- load rdata_o with the byte at the latched offset, taken from mem_data_i if offset == last beat, else from the array;
- drop mem_req_o the next cycle and enter RESPOND.
REQ-012 mem_ack_i outside REFILL SHALL be ignored. req_i and flush_i outside IDLE SHALL be ignored.
REQ-013 FLUSH SHALL clear one valid bit per cycle, index 0 to 2^INDEX_W-1 (16 cycles by default), then return to IDLE. Counters are not reset by flush.
REQ-014 Counters SHALL saturate at 16'hFFFF with no wrap.
REQ-015 rdata_o SHALL hold its last value outside RESPOND. mem_addr_o SHALL hold its last value when mem_req_o = 0.

Reset
REQ-016 rst_ni low SHALL asynchronously force the following, including mid-REFILL or mid-FLUSH (an interrupted line stays invalid):
- state IDLE;
- all valid bits 0;
- ready_o = 1;
- rvalid_o, mem_req_o, rdata_o, mem_addr_o, hit_cnt_o, miss_cnt_o = 0.
REQ-017 Tag and data arrays need no reset.

Verification
REQ-018 Cold miss: reset, req addr 0x100, mem acks each beat with data 0xA0-0xA3 -> mem_addr_o 0x100-0x103 in order, rvalid_o with rdata_o 0xA0, miss_cnt_o = 1.
REQ-019 Hit: then req 0x102 -> rvalid_o exactly 2 cycles after acceptance, rdata_o 0xA2, no mem_req_o, hit_cnt_o = 1.
REQ-020 Conflict: req 0x200, then 0x100 (same index 0) -> both miss (miss_cnt_o = 3), with a second refill of line 0x100. Ack delayed 3 cycles per beat -> mem_addr_o stable while waiting.
REQ-021 Flush: flush_i and req_i together in IDLE -> ready_o low for 16 cycles, request ignored. Subsequent req 0x100 -> miss.
REQ-022 Reset mid-REFILL after 2 acks -> mem_req_o 0 immediately. Req of the same address afterwards -> full 4-beat refill from beat 0.
REQ-023 Saturation: force 65536+ hits -> hit_cnt_o stays 0xFFFF.

Source files
------------

// File: rtl/cache_ctrl.sv
// cache_ctrl: direct-mapped read-only byte cache with byte-wide refill, flush and saturating hit/miss counters
module cache_ctrl #(
  parameter int ADDR_W   = 32,
  parameter int INDEX_W  = 4,
  parameter int OFFSET_W = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic              ready_o,
  output logic              rvalid_o,
  output logic [7:0]        rdata_o,
  input  logic              flush_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ack_i,
  input  logic [7:0]        mem_data_i,
  output logic [15:0]       hit_cnt_o,
  output logic [15:0]       miss_cnt_o
);
  localparam int LINES = 1 << INDEX_W;
  localparam int BYTES = 1 << OFFSET_W;
  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
  typedef enum logic [2:0] {IDLE, LOOKUP, REFILL, RESPOND, FLUSH} state_t;
  state_t state, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [TAG_W-1:0]    tags [LINES];
  logic [7:0]          data [LINES][BYTES];
  logic [LINES-1:0]    valid;
  logic [OFFSET_W-1:0] beat, beat_n;
  logic [INDEX_W-1:0]  fidx;
  logic [TAG_W-1:0]    tag;
  logic [INDEX_W-1:0]  idx;
  logic [OFFSET_W-1:0] off;
  logic                hit, last;
  assign tag       = addr_q[ADDR_W-1:INDEX_W+OFFSET_W];
  assign idx       = addr_q[INDEX_W+OFFSET_W-1:OFFSET_W];
  assign off       = addr_q[OFFSET_W-1:0];
  assign hit       = valid[idx] && tags[idx] == tag;
  assign last      = &beat;
  assign beat_n    = beat + OFFSET_W'(1);
  assign ready_o   = state == IDLE;
  assign rvalid_o  = state == RESPOND;
  assign mem_req_o = state == REFILL;
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    state_d = flush_i ? FLUSH : req_i ? LOOKUP : IDLE;
      LOOKUP:  state_d = hit ? RESPOND : REFILL;
      REFILL:  state_d = mem_ack_i && last ? RESPOND : REFILL;
      RESPOND: state_d = IDLE;
      FLUSH:   state_d = &fidx ? IDLE : FLUSH;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      valid      <= '0;
      rdata_o    <= '0;
      mem_addr_o <= '0;
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
      addr_q     <= '0;
      beat       <= '0;
      fidx       <= '0;
    end else begin
      state <= state_d;
      case (state)
        IDLE: begin
          if (!flush_i && req_i) addr_q <= addr_i;
          fidx <= '0;
        end
        LOOKUP:
          if (hit) begin
            hit_cnt_o <= hit_cnt_o + 16'(~&hit_cnt_o);
            rdata_o   <= data[idx][off];
          end else begin
            miss_cnt_o <= miss_cnt_o + 16'(~&miss_cnt_o);
            valid[idx] <= 1'b0;
            beat       <= '0;
            mem_addr_o <= {tag, idx, {OFFSET_W{1'b0}}};
          end
        REFILL:
          if (mem_ack_i) begin
            beat <= beat_n;
            if (last) begin
              valid[idx] <= 1'b1;
              // the final beat is not in the array yet, so bypass it from the bus
              rdata_o    <= off == beat ? mem_data_i : data[idx][off];
            end else mem_addr_o <= {tag, idx, beat_n};
          end
        FLUSH: begin
          valid[fidx] <= 1'b0;
          fidx        <= fidx + INDEX_W'(1);
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk_i) begin
    if (state == REFILL && mem_ack_i) begin
      data[idx][beat] <= mem_data_i;
      if (last) tags[idx] <= tag;
    end
  end
endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl: directed table-driven bench for cache_ctrl with a delayed-ack byte memory model
module tb_cache_ctrl;
  logic        clk = 0, rst_n = 0, req = 0, flush = 0, mem_ack = 0;
  logic [31:0] addr = '0;
  logic [7:0]  mem_data = '0;
  logic        ready_o, rvalid_o, mem_req_o;
  logic [7:0]  rdata_o;
  logic [31:0] mem_addr_o;
  logic [15:0] hit_cnt_o, miss_cnt_o;
  int checks = 0, errors = 0, ack_dly = 0;
  logic [31:0] addr_log[$];
  typedef struct {
    logic [31:0] a;
    bit          hit;
    logic [7:0]  d;
    logic [15:0] h, m;
    int          dly;
  } vec_t;
  vec_t v[9];
  cache_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .addr_i(addr), .ready_o(ready_o),
    .rvalid_o(rvalid_o), .rdata_o(rdata_o), .flush_i(flush), .mem_req_o(mem_req_o),
    .mem_addr_o(mem_addr_o), .mem_ack_i(mem_ack), .mem_data_i(mem_data),
    .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    return a[7:0] + {a[11:8], 4'h0} + 8'h90;
  endfunction
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  // memory model: acks each beat ack_dly cycles after it is requested
  initial begin
    int wcnt = 0;
    logic [31:0] wait_addr = '0;
    forever begin
      @(negedge clk);
      mem_ack = 0;
      if (mem_req_o) begin
        if (wcnt == 0) wait_addr = mem_addr_o;
        else chk("addr_stable", mem_addr_o, wait_addr);
        if (wcnt == ack_dly) begin
          mem_ack  = 1;
          mem_data = mem_byte(mem_addr_o);
          addr_log.push_back(mem_addr_o);
          wcnt = 0;
        end else wcnt++;
      end else wcnt = 0;
    end
  end
  task automatic do_read(input logic [31:0] a, input bit exp_hit, input logic [7:0] exp_d,
                         input logic [15:0] eh, input logic [15:0] em, input int dly);
    int n = 0, lat = 1;
    bit saw_mreq = 0;
    logic [31:0] base;
    ack_dly = dly;
    addr_log.delete();
    while (!ready_o && n < 50) begin @(negedge clk); n++; end
    chk("ready_before_req", {31'd0, ready_o}, 32'd1);
    req = 1; addr = a;
    @(posedge clk);
    @(negedge clk);
    req = 0;
    while (!rvalid_o && lat < 100) begin
      saw_mreq |= mem_req_o;
      @(negedge clk);
      lat++;
    end
    chk("rvalid", {31'd0, rvalid_o}, 32'd1);
    chk("rdata", {24'd0, rdata_o}, {24'd0, exp_d});
    if (exp_hit) begin
      chk("hit_latency", lat, 2);
      chk("hit_no_mem_req", {31'd0, saw_mreq}, 32'd0);
    end else begin
      base = {a[31:2], 2'b00};
      chk("beats", addr_log.size(), 4);
      for (int i = 0; i < 4 && i < addr_log.size(); i++) chk("beat_addr", addr_log[i], base + i);
      chk("mem_addr_hold", mem_addr_o, base + 3);
    end
    @(negedge clk);
    chk("rvalid_pulse", {31'd0, rvalid_o}, 32'd0);
    chk("mem_req_idle", {31'd0, mem_req_o}, 32'd0);
    chk("rdata_hold", {24'd0, rdata_o}, {24'd0, exp_d});
    chk("hit_cnt", {16'd0, hit_cnt_o}, {16'd0, eh});
    chk("miss_cnt", {16'd0, miss_cnt_o}, {16'd0, em});
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    int n;
    bit bad;
    v[0] = '{32'h100, 0, 8'hA0, 16'd0, 16'd1, 0};
    v[1] = '{32'h102, 1, 8'hA2, 16'd1, 16'd1, 0};
    v[2] = '{32'h200, 0, 8'hB0, 16'd1, 16'd2, 3};
    v[3] = '{32'h100, 0, 8'hA0, 16'd1, 16'd3, 3};
    v[4] = '{32'h103, 1, 8'hA3, 16'd2, 16'd3, 0};
    v[5] = '{32'h207, 0, 8'hB7, 16'd2, 16'd4, 1};
    v[6] = '{32'h205, 1, 8'hB5, 16'd3, 16'd4, 0};
    v[7] = '{32'h100, 0, 8'hA0, 16'd3, 16'd5, 0};
    v[8] = '{32'h205, 0, 8'hB5, 16'd3, 16'd6, 2};
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, ready_o}, 32'd1);
    chk("rst_rvalid", {31'd0, rvalid_o}, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
    chk("rst_rdata", {24'd0, rdata_o}, 32'd0);
    chk("rst_mem_addr", mem_addr_o, 32'd0);
    chk("rst_hit", {16'd0, hit_cnt_o}, 32'd0);
    chk("rst_miss", {16'd0, miss_cnt_o}, 32'd0);
    rst_n = 1;
    @(negedge clk);
    for (int i = 0; i < 7; i++) do_read(v[i].a, v[i].hit, v[i].d, v[i].h, v[i].m, v[i].dly);
    flush = 1; req = 1; addr = 32'h100;
    @(posedge clk);
    @(negedge clk);
    flush = 0; req = 0;
    n = 0; bad = 0;
    while (!ready_o && n < 40) begin
      bad |= rvalid_o | mem_req_o;
      n++;
      @(negedge clk);
    end
    chk("flush_cycles", n, 16);
    chk("flush_quiet", {31'd0, bad}, 32'd0);
    chk("flush_hit_cnt", {16'd0, hit_cnt_o}, 32'd3);
    chk("flush_miss_cnt", {16'd0, miss_cnt_o}, 32'd4);
    for (int i = 7; i < 9; i++) do_read(v[i].a, v[i].hit, v[i].d, v[i].h, v[i].m, v[i].dly);
    ack_dly = 2;
    addr_log.delete();
    req = 1; addr = 32'h300;
    @(posedge clk);
    @(negedge clk);
    req = 0;
    n = 0;
    while (addr_log.size() < 2 && n < 50) begin @(negedge clk); n++; end
    chk("two_acks_seen", addr_log.size(), 2);
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("rst_mid_mem_req", {31'd0, mem_req_o}, 32'd0);
    chk("rst_mid_ready", {31'd0, ready_o}, 32'd1);
    chk("rst_mid_mem_addr", mem_addr_o, 32'd0);
    chk("rst_mid_miss", {16'd0, miss_cnt_o}, 32'd0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    do_read(32'h300, 0, 8'hC0, 16'd0, 16'd1, 0);
    force dut.hit_cnt_o = 16'hFFFD;
    #1;
    release dut.hit_cnt_o;
    @(negedge clk);
    do_read(32'h301, 1, 8'hC1, 16'hFFFE, 16'd1, 0);
    do_read(32'h301, 1, 8'hC1, 16'hFFFF, 16'd1, 0);
    do_read(32'h302, 1, 8'hC2, 16'hFFFF, 16'd1, 0);
    do_read(32'h303, 1, 8'hC3, 16'hFFFF, 16'd1, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
